inv_round_front_stage: RTL and testbench

//  Elastic two-stage pipeline computing the front half of one AES inverse round:

---
 rtl/inv_round_front_stage_pkg.sv | 35 +++
 rtl/inv_sbox.sv | 37 +++
 rtl/inv_round_front_stage.sv | 100 ++++++++++
 tb/tb_inv_round_front_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_round_front_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inv_round_front_stage_pkg
// Brief   : Shared widths, byte-index helper and stage payload types for the
//           AES inverse-round front stage.
// Revision: 1.0 - initial release
// ============================================================================
package inv_round_front_stage_pkg;

  localparam int c_aes_w  = 128;
  localparam int c_byte   = 8;
  localparam int c_nbytes = c_aes_w / c_byte;

  // Byte i is row i%4, column i/4; output (r,c) takes input (r,(c-r) mod 4).
  function automatic int inv_shift_src(input int i);
    int r;
    int c;
    r = i % 4;
    c = i / 4;
    return r + 4 * ((c - r + 4) % 4);
  endfunction

  typedef struct packed {
    logic [c_aes_w-1:0] data;
    logic [c_aes_w-1:0] key;
    logic               last;
  } stage_a_t;

  typedef struct packed {
    logic [c_aes_w-1:0] data;
    logic               last;
  } stage_b_t;

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// Module  : inv_sbox
// Brief   : AES inverse S-box, combinational 256-entry lookup.
// Revision: 1.0 - initial release
// ============================================================================
module inv_sbox
  import inv_round_front_stage_pkg::*;
(
  input  logic [c_byte-1:0] din,
  output logic [c_byte-1:0] dout
);

  // Entry 0 sits in the most-significant byte, one 16-entry row per line.
  localparam logic [256*c_byte-1:0] c_table = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign dout = c_table[{~din, 3'b000} +: c_byte];

endmodule
`default_nettype wire

// File: rtl/inv_round_front_stage.sv
`default_nettype none
// ============================================================================
// Module  : inv_round_front_stage
// Brief   : Elastic pipeline for InvShiftRows -> InvSubBytes -> AddRoundKey.
// Revision: 1.0 - initial release
// ============================================================================
module inv_round_front_stage
  import inv_round_front_stage_pkg::*;
#(
  parameter int SBOX_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [c_aes_w-1:0] in_state,
  input  logic [c_aes_w-1:0] in_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [c_aes_w-1:0] out_state,
  output logic               out_last
);

  logic [c_aes_w-1:0] w_shifted;
  logic [c_aes_w-1:0] w_subbed;
  logic               w_adv_b;
  logic               w_b_src_valid;
  stage_b_t           w_b_next;
  logic               r_b_valid;
  stage_b_t           r_b;

  generate
    for (genvar gi = 0; gi < c_nbytes; gi++) begin : g_byte
      localparam int c_src = inv_shift_src(gi);

      assign w_shifted[c_aes_w-1-c_byte*gi -: c_byte] =
        in_state[c_aes_w-1-c_byte*c_src -: c_byte];

      inv_sbox u_inv_sbox (
        .din  (w_shifted[c_aes_w-1-c_byte*gi -: c_byte]),
        .dout (w_subbed[c_aes_w-1-c_byte*gi -: c_byte])
      );
    end
  endgenerate

  assign w_adv_b = !r_b_valid || out_ready;

  generate
    if (SBOX_REG != 0) begin : g_two_stage
      logic     r_a_valid;
      stage_a_t r_a;
      logic     w_adv_a;

      assign w_adv_a       = !r_a_valid || w_adv_b;
      assign in_ready      = w_adv_a;
      assign w_b_src_valid = r_a_valid;
      assign w_b_next.data = r_a.data ^ r_a.key;
      assign w_b_next.last = r_a.last;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_valid <= 1'b0;
          r_a       <= '0;
        end else if (w_adv_a) begin
          r_a_valid <= in_valid;
          if (in_valid) begin
            r_a.data <= w_subbed;
            r_a.key  <= in_key;
            r_a.last <= in_last;
          end
        end
      end
    end else begin : g_one_stage
      assign in_ready      = w_adv_b;
      assign w_b_src_valid = in_valid;
      assign w_b_next.data = w_subbed ^ in_key;
      assign w_b_next.last = in_last;
    end
  endgenerate

  // Output stage only loads real beats so out_state stays put while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b       <= '0;
    end else if (w_adv_b) begin
      r_b_valid <= w_b_src_valid;
      if (w_b_src_valid) begin
        r_b <= w_b_next;
      end
    end
  end

  assign out_valid = r_b_valid;
  assign out_state = r_b.data;
  assign out_last  = r_b.last;

endmodule
`default_nettype wire

// File: tb/tb_inv_round_front_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_inv_round_front_stage
// Brief   : Self-checking bench for both SBOX_REG builds against a byte-matrix
//           AES model with a GF(2^8)-derived inverse S-box.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inv_round_front_stage;

  typedef struct packed {
    logic [127:0] st;
    logic         last;
  } beat_t;

  localparam logic [127:0] c_r1_in   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] c_r1_key  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] c_r1_out  = 128'he9f74eec023020f61bf2ccf2353c21c7;
  localparam logic [127:0] c_r10_in  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] c_r10_key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_r10_out = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid  = '0;
  logic [1:0]   in_last   = '0;
  logic [1:0]   out_ready = '0;
  logic [1:0]   in_ready;
  logic [1:0]   out_valid;
  logic [1:0]   out_last;
  logic [127:0] in_state [2];
  logic [127:0] in_key   [2];
  logic [127:0] out_state[2];

  int     checks = 0;
  int     errors = 0;
  int     cur    = 1;
  int     n_acc  = 0;
  int     n_del  = 0;
  beat_t  exp_q[$];
  logic [7:0] inv_sb [256];

  inv_round_front_stage #(.SBOX_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
    .in_key(in_key[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .out_last(out_last[0])
  );

  inv_round_front_stage #(.SBOX_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
    .in_key(in_key[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .out_last(out_last[1])
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Forward S-box = affine(multiplicative inverse); invert it into a table.
  task automatic build_inv_sb();
    logic [7:0] ix;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      ix = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) ix = 8'(y);
      s = ix ^ rotl(ix, 1) ^ rotl(ix, 2) ^ rotl(ix, 3) ^ rotl(ix, 4) ^ 8'h63;
      inv_sb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = st[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = inv_sb[m[r][(c-r+4)%4]] ^ key[127-8*(4*c+r) -: 8];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (dut%0d): got %h expected %h", name, cur, act, expv);
    end
  endtask

  task automatic rand_payload();
    in_state[cur] = {$urandom, $urandom, $urandom, $urandom};
    in_key[cur]   = {$urandom, $urandom, $urandom, $urandom};
    in_last[cur]  = 1'($urandom_range(1));
  endtask

  // Sample handshakes mid-cycle, score deliveries, log acceptances, advance.
  task automatic cycle();
    beat_t b;
    logic  acc;
    logic  del;
    #1;
    acc = in_valid[cur] && in_ready[cur];
    del = out_valid[cur] && out_ready[cur];
    if (del) begin
      n_del++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat (dut%0d): got %h expected no beat", cur, out_state[cur]);
      end else begin
        b = exp_q.pop_front();
        chk("out_state", out_state[cur], b.st);
        chk("out_last", 128'(out_last[cur]), 128'(b.last));
      end
    end
    if (acc) begin
      n_acc++;
      b.st   = model(in_state[cur], in_key[cur]);
      b.last = in_last[cur];
      exp_q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic vec(input int lat, input logic [127:0] st, input logic [127:0] key,
                     input logic last, input logic [127:0] expv);
    out_ready[cur] = 1'b1;
    in_valid[cur]  = 1'b1;
    in_state[cur]  = st;
    in_key[cur]    = key;
    in_last[cur]   = last;
    cycle();
    in_valid[cur] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      #1;
      chk("vec_early_valid", 128'(out_valid[cur]), 128'(0));
      cycle();
    end
    #1;
    chk("vec_valid", 128'(out_valid[cur]), 128'(1));
    chk("vec_state", out_state[cur], expv);
    chk("vec_last", 128'(out_last[cur]), 128'(last));
    cycle();
  endtask

  task automatic suite(input int lat);
    int acc0;
    int k;
    vec(lat, c_r1_in, c_r1_key, 1'b0, c_r1_out);
    vec(lat, c_r10_in, c_r10_key, 1'b1, c_r10_out);

    out_ready[cur] = 1'b1;
    for (int s = 0; s < 8 + lat; s++) begin
      in_valid[cur] = (s < 8);
      rand_payload();
      #1;
      if (s < 8) chk("stream_in_ready", 128'(in_ready[cur]), 128'(1));
      if (s >= lat) chk("stream_out_valid", 128'(out_valid[cur]), 128'(1));
      cycle();
    end
    in_valid[cur] = 1'b0;
    chk("stream_drained", 128'(exp_q.size()), 128'(0));

    out_ready[cur] = 1'b0;
    acc0 = n_acc;
    for (int s = 0; s < 5; s++) begin
      in_valid[cur] = 1'b1;
      rand_payload();
      cycle();
    end
    #1;
    chk("bp_accepted", 128'(n_acc - acc0), 128'(lat));
    chk("bp_in_ready", 128'(in_ready[cur]), 128'(0));
    chk("bp_out_valid", 128'(out_valid[cur]), 128'(1));
    if (exp_q.size() > 0) chk("bp_hold_state", out_state[cur], exp_q[0].st);
    in_valid[cur] = 1'b0;
    cycle();
    out_ready[cur] = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      cycle();
      k++;
    end
    chk("bp_drained", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic random_run(input int nbeats);
    int cyc;
    int a0;
    int d0;
    cyc = 0;
    a0  = n_acc;
    d0  = n_del;
    while (((n_acc - a0) < nbeats || exp_q.size() != 0) && cyc < 30000) begin
      in_valid[cur]  = ((n_acc - a0) < nbeats) && ($urandom_range(3) != 0);
      rand_payload();
      out_ready[cur] = ($urandom_range(3) != 0);
      cycle();
      cyc++;
    end
    in_valid[cur] = 1'b0;
    if (cyc >= 30000) begin
      checks++;
      errors++;
      $display("FAIL rand_timeout (dut%0d): got %0d cycles required fewer than 30000", cur, cyc);
    end
    chk("rand_no_loss", 128'(exp_q.size()), 128'(0));
    chk("rand_delivered", 128'(n_del - d0), 128'(nbeats));
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      in_state[l] = '0;
      in_key[l]   = '0;
    end
    build_inv_sb();

    #2;
    for (int l = 0; l < 2; l++) begin
      cur = l;
      chk("reset_out_valid", 128'(out_valid[l]), 128'(0));
      chk("reset_out_state", out_state[l], 128'h0);
      chk("reset_out_last", 128'(out_last[l]), 128'(0));
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      cur = l;
      chk("reset_in_ready", 128'(in_ready[l]), 128'(1));
    end
    @(negedge clk);

    cur = 1;
    suite(2);
    cur = 0;
    suite(1);

    // Reset with two beats in flight in the registered build.
    cur = 1;
    out_ready[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[1] = 1'b1;
      rand_payload();
      cycle();
    end
    in_valid[1] = 1'b0;
    #1;
    chk("midrst_inflight", 128'(out_valid[1]), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid[1]), 128'(0));
    chk("midrst_out_state", out_state[1], 128'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec(2, c_r1_in, c_r1_key, 1'b0, c_r1_out);

    cur = 1;
    random_run(10000);
    cur = 0;
    random_run(10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
